// File: rtl/sdatamem_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sdatamem_pipe
// Purpose  : Byte-addressable little-endian scalar data memory. It has a
//            valid/ready request port, responses that come back in order
//            after READ_LAT cycles, and a sequenced clear that runs after
//            reset. Defining SDATAMEM_STATS_EN adds saturating
//            load/store/error counters.
// Revision : 1.0 - initial release
// ============================================================================
module sdatamem_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_BYTES  = 4096,
    parameter int ADDR_WIDTH = 32,
    parameter int READ_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o,
`ifdef SDATAMEM_STATS_EN
    output logic [31:0]           stat_loads_o,
    output logic [31:0]           stat_stores_o,
    output logic [15:0]           stat_errs_o,
`endif
    output logic                  init_done_o
);

    localparam int BPW   = DATA_WIDTH / 8;
    localparam int WORDS = MEM_BYTES / BPW;
    localparam int OFF_W = $clog2(BPW);
    localparam int MB_W  = $clog2(MEM_BYTES);
    localparam int IDX_W = MB_W - OFF_W;
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(MEM_BYTES);

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    generate
        if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
            $error("sdatamem_pipe: DATA_WIDTH must be 32 or 64");
        end
        if ((MEM_BYTES & (MEM_BYTES - 1)) != 0 || MEM_BYTES < 2 * BPW) begin : g_bad_bytes
            $error("sdatamem_pipe: MEM_BYTES must be a power of two holding at least two words");
        end
        if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
            $error("sdatamem_pipe: READ_LAT must be in 1..4");
        end
        if (ADDR_WIDTH < MB_W || ADDR_WIDTH < 4) begin : g_bad_addr
            $error("sdatamem_pipe: ADDR_WIDTH too narrow for MEM_BYTES");
        end
    endgenerate

    logic [0:0]            state;
    logic [0:0]            state_nxt;
    logic [IDX_W-1:0]      clr_cnt;

    logic                  accept;
    logic                  err;
    logic                  misalign;
    logic                  store_ok;
    logic                  load_ok;
    logic [3:0]            size_bytes;
    logic [2:0]            align_mask;
    logic [ADDR_WIDTH:0]   end_addr;
    logic [IDX_W-1:0]      idx;
    logic [OFF_W-1:0]      off;
    logic [6:0]            nbits;
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] keep;
    logic [DATA_WIDTH-1:0] top_bit;
    logic                  sbit;
    logic [DATA_WIDTH-1:0] load_val;
    logic [DATA_WIDTH-1:0] wdata_sh;
    logic [BPW-1:0]        bmask;

    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic [READ_LAT-1:0]   pipe_valid;
    logic [READ_LAT-1:0]   pipe_err;
    logic [DATA_WIDTH-1:0] pipe_data [READ_LAT];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (clr_cnt == IDX_W'(WORDS - 1)) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        req_ready_o = 1'b0;
        init_done_o = 1'b0;
        if (state == S_RUN) begin
            req_ready_o = 1'b1;
            init_done_o = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt <= '0;
        end else if (state == S_INIT) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // ---------------- request decode ----------------
    assign accept     = req_valid_i & req_ready_o;
    assign size_bytes = 4'd1 << req_size_i;
    assign end_addr   = {1'b0, req_addr_i} + {{(ADDR_WIDTH-3){1'b0}}, size_bytes};

    always_comb begin
        align_mask = 3'b000;
        case (req_size_i)
            2'b00:   align_mask = 3'b000;
            2'b01:   align_mask = 3'b001;
            2'b10:   align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    end

    assign misalign = |(req_addr_i[2:0] & align_mask);
    assign err      = misalign | (end_addr > LIMIT) | ((req_size_i == 2'b11) && (DATA_WIDTH == 32));
    assign store_ok = accept & req_write_i & ~err;
    assign load_ok  = accept & ~req_write_i & ~err;

    // A legal access is aligned and never wider than a word, so it stays inside one word.
    assign idx      = req_addr_i[MB_W-1:OFF_W];
    assign off      = req_addr_i[OFF_W-1:0];
    assign nbits    = {size_bytes, 3'b000};
    assign word     = mem[idx];
    assign shifted  = word >> {off, 3'b000};
    assign keep     = ~({DATA_WIDTH{1'b1}} << nbits);
    assign top_bit  = keep & ~(keep >> 1);
    assign sbit     = |(shifted & top_bit);
    assign load_val = (shifted & keep) | ({DATA_WIDTH{sbit & ~req_unsigned_i}} & ~keep);
    assign wdata_sh = req_wdata_i << {off, 3'b000};
    assign bmask    = ~({BPW{1'b1}} << size_bytes) << off;

    // Storage carries no reset; the INIT sweep zeroes one word per cycle instead.
    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            mem[clr_cnt] <= '0;
        end else if (store_ok) begin
            for (int b = 0; b < BPW; b++) begin
                if (bmask[b]) begin
                    mem[idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
                end
            end
        end
    end

    // ---------------- response pipeline ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_err[0]   <= accept & err;
            pipe_data[0]  <= load_ok ? load_val : '0;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    assign resp_valid_o = pipe_valid[READ_LAT-1];
    assign resp_err_o   = pipe_err[READ_LAT-1];
    assign resp_rdata_o = pipe_data[READ_LAT-1];

`ifdef SDATAMEM_STATS_EN
    logic [31:0] cnt_loads;
    logic [31:0] cnt_stores;
    logic [15:0] cnt_errs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_loads  <= '0;
            cnt_stores <= '0;
            cnt_errs   <= '0;
        end else if (accept) begin
            if (err) begin
                if (~&cnt_errs) cnt_errs <= cnt_errs + 1'b1;
            end else if (req_write_i) begin
                if (~&cnt_stores) cnt_stores <= cnt_stores + 1'b1;
            end else begin
                if (~&cnt_loads) cnt_loads <= cnt_loads + 1'b1;
            end
        end
    end

    assign stat_loads_o  = cnt_loads;
    assign stat_stores_o = cnt_stores;
    assign stat_errs_o   = cnt_errs;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdatamem_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdatamem_pipe
// Purpose  : Bench for sdatamem_pipe. It compares a 32-bit instance against a
//            byte-array reference model, and runs directed checks on a 64-bit
//            instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdatamem_pipe;

    localparam int MEMB  = 4096;
    localparam int RL    = 4;
    localparam int WORDS = MEMB / 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic        resp_valid, resp_err, init_done;

    logic        b_valid, b_ready, b_write, b_unsigned;
    logic [1:0]  b_size;
    logic [31:0] b_addr;
    logic [63:0] b_wdata, b_rdata;
    logic        b_resp_valid, b_err, b_init_done;

`ifdef SDATAMEM_STATS_EN
    logic [31:0] stat_loads, stat_stores, b_stat_loads, b_stat_stores;
    logic [15:0] stat_errs, b_stat_errs;
`endif

    sdatamem_pipe #(.DATA_WIDTH(32), .MEM_BYTES(MEMB), .ADDR_WIDTH(32), .READ_LAT(RL)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
        .resp_err_o(resp_err),
`ifdef SDATAMEM_STATS_EN
        .stat_loads_o(stat_loads), .stat_stores_o(stat_stores), .stat_errs_o(stat_errs),
`endif
        .init_done_o(init_done)
    );

    sdatamem_pipe #(.DATA_WIDTH(64), .MEM_BYTES(MEMB), .ADDR_WIDTH(32), .READ_LAT(3)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(b_valid), .req_ready_o(b_ready), .req_write_i(b_write),
        .req_size_i(b_size), .req_unsigned_i(b_unsigned), .req_addr_i(b_addr),
        .req_wdata_i(b_wdata), .resp_valid_o(b_resp_valid), .resp_rdata_o(b_rdata),
        .resp_err_o(b_err),
`ifdef SDATAMEM_STATS_EN
        .stat_loads_o(b_stat_loads), .stat_stores_o(b_stat_stores), .stat_errs_o(b_stat_errs),
`endif
        .init_done_o(b_init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic        e;
        int          t;
    } rec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   edges = 0;
    int   since = 0;
    int   nl = 0, ns = 0, ne = 0;
    rec_t q[$];
    rec_t log32[$];
    rec_t log64[$];
    bit [7:0] mmem [MEMB];

    always @(posedge clk) edges <= edges + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) since <= 0;
        else        since <= since + 1;
    end

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference: plain byte array, little-endian assembly, arithmetic extension.
    function automatic void model(input bit wr, input bit [1:0] sz, input bit uns,
                                  input bit [31:0] a, input bit [31:0] wd,
                                  output bit [31:0] rd, output bit er);
        int       n;
        bit [63:0] v;
        n  = 1 << sz;
        v  = '0;
        rd = '0;
        er = (a % n != 0) || ({32'd0, a} + 64'(n) > 64'(MEMB)) || (sz == 2'd3);
        if (!er) begin
            if (wr) begin
                for (int i = 0; i < n; i++) mmem[a + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) v[8*i +: 8] = mmem[a + i];
                if (!uns && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
                rd = v[31:0];
            end
        end
    endfunction

    always @(negedge clk) begin
        bit [31:0] rd;
        bit        er;
        bit        exp_ready;
        rec_t      r;
        if (!rst_n) begin
            q.delete();
            for (int i = 0; i < MEMB; i++) mmem[i] = 8'h00;
            nl = 0; ns = 0; ne = 0;
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_ready", req_ready, 0);
            chk("rst_init_done", init_done, 0);
`ifdef SDATAMEM_STATS_EN
            chk("rst_stat_loads", stat_loads, 0);
            chk("rst_stat_stores", stat_stores, 0);
            chk("rst_stat_errs", stat_errs, 0);
`endif
        end else begin
            exp_ready = (since >= WORDS);
            chk("ready", req_ready, exp_ready);
            chk("init_done", init_done, exp_ready);
`ifdef SDATAMEM_STATS_EN
            chk("stat_loads", stat_loads, nl);
            chk("stat_stores", stat_stores, ns);
            chk("stat_errs", stat_errs, ne);
`endif
            if (resp_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_resp_valid", resp_valid, 0);
                end else begin
                    r = q.pop_front();
                    chk("resp_cycle", edges, r.t);
                    chk("resp_rdata", resp_rdata, r.d);
                    chk("resp_err", resp_err, r.e);
                end
            end else if (q.size() != 0 && q[0].t <= edges) begin
                chk("missing_resp_valid", resp_valid, 1);
                void'(q.pop_front());
            end
            if (req_valid && exp_ready) begin
                model(req_write, req_size, req_unsigned, req_addr, req_wdata, rd, er);
                r.d = 64'(rd); r.e = er; r.t = edges + RL;
                q.push_back(r);
                if (er) ne++;
                else if (req_write) ns++;
                else nl++;
            end
        end
    end

    always @(negedge clk) begin
        rec_t r;
        if (rst_n && resp_valid) begin
            r.d = 64'(resp_rdata); r.e = resp_err; r.t = edges;
            log32.push_back(r);
        end
        if (rst_n && b_resp_valid) begin
            r.d = b_rdata; r.e = b_err; r.t = edges;
            log64.push_back(r);
        end
    end

    task automatic issue(input bit wr, input bit [1:0] sz, input bit uns, input bit [31:0] a, input bit [31:0] wd);
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic issue64(input bit wr, input bit [1:0] sz, input bit uns, input bit [31:0] a, input bit [63:0] wd);
        @(posedge clk); #1;
        b_valid = 1'b1; b_write = wr; b_size = sz; b_unsigned = uns; b_addr = a; b_wdata = wd;
    endtask

    task automatic idle64(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            b_valid = 1'b0;
        end
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        @(negedge clk);
        while (!init_done && n < 1200) begin
            @(negedge clk);
            n++;
        end
        chk("init_cycles", since, WORDS);
    endtask

    task automatic check_log(input int i, input string nm, input logic [63:0] d, input logic e);
        if (log32.size() > i) begin
            chk({nm, "_rdata"}, log32[i].d, d);
            chk({nm, "_err"}, log32[i].e, e);
        end else begin
            chk({nm, "_present"}, log32.size(), i + 1);
        end
    endtask

    task automatic check_log64(input int i, input string nm, input logic [63:0] d, input logic e);
        if (log64.size() > i) begin
            chk({nm, "_rdata"}, log64[i].d, d);
            chk({nm, "_err"}, log64[i].e, e);
        end else begin
            chk({nm, "_present"}, log64.size(), i + 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish before %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        int acc0;
        bit [1:0]  sz;
        bit [31:0] a;
        int        r;
        req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
        b_valid = 0; b_write = 0; b_size = 0; b_unsigned = 0; b_addr = 0; b_wdata = 0;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_init();

        log32.delete();
        issue(0, 2'd2, 0, 32'hFFC, 0);
        idle(RL + 3);
        check_log(0, "load_ffc", 64'h0, 1'b0);

        log32.delete();
        issue(1, 2'd2, 0, 32'h100, 32'h8001_F0A5);
        acc0 = edges + 1;
        issue(0, 2'd0, 0, 32'h100, 0);
        issue(0, 2'd1, 1, 32'h102, 0);
        idle(RL + 3);
        check_log(0, "store_w100", 64'h0, 1'b0);
        check_log(1, "load_b100_s", 64'hFFFF_FFA5, 1'b0);
        check_log(2, "load_h102_u", 64'h0000_8001, 1'b0);
        if (log32.size() == 3) begin
            chk("first_latency", log32[0].t, acc0 + RL - 1);
            chk("b2b_resp_1", log32[1].t, log32[0].t + 1);
            chk("b2b_resp_2", log32[2].t, log32[1].t + 1);
        end

        log32.delete();
        issue(1, 2'd1, 0, 32'h101, 32'h0000_BEEF);
        issue(0, 2'd2, 0, 32'hFFE, 0);
        issue(0, 2'd2, 0, 32'h100, 0);
        issue(0, 2'd3, 0, 32'h0, 0);
        idle(RL + 3);
        check_log(0, "store_h101_mis", 64'h0, 1'b1);
        check_log(1, "load_wffe_oob", 64'h0, 1'b1);
        check_log(2, "load_w100_kept", 64'h8001_F0A5, 1'b0);
        check_log(3, "load_d_on32", 64'h0, 1'b1);

        log64.delete();
        chk("init64_done", b_init_done, 1);
        issue64(1, 2'd3, 0, 32'h8, 64'h0123_4567_89AB_CDEF);
        acc0 = edges + 1;
        issue64(0, 2'd2, 0, 32'hC, 0);
        issue64(0, 2'd2, 0, 32'h8, 0);
        issue64(0, 2'd3, 0, 32'h8, 0);
        issue64(0, 2'd0, 1, 32'hF, 0);
        issue64(0, 2'd3, 0, 32'h4, 0);
        idle64(6);
        check_log64(0, "d64_store_d8", 64'h0, 1'b0);
        check_log64(1, "d64_load_wc_s", 64'h0000_0000_0123_4567, 1'b0);
        check_log64(2, "d64_load_w8_s", 64'hFFFF_FFFF_89AB_CDEF, 1'b0);
        check_log64(3, "d64_load_d8", 64'h0123_4567_89AB_CDEF, 1'b0);
        check_log64(4, "d64_load_bf_u", 64'h0000_0000_0000_0001, 1'b0);
        check_log64(5, "d64_load_d4_mis", 64'h0, 1'b1);
        if (log64.size() > 0) chk("d64_latency", log64[0].t, acc0 + 2);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 8) begin
                sz = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                r  = $urandom_range(0, 19);
                if (r < 15) begin
                    a = 32'h100 + $urandom_range(0, 63);
                    if ($urandom_range(0, 4) != 0) a = a & ~((32'd1 << sz) - 32'd1);
                end else if (r < 18) begin
                    a = 32'hFF0 + $urandom_range(0, 15);
                end else begin
                    a = $urandom_range(0, 32'h1FFF);
                end
                issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
            end else begin
                idle(1);
            end
        end
        idle(RL + 3);

        log32.delete();
        issue(0, 2'd2, 0, 32'h100, 0);
        issue(0, 2'd2, 0, 32'h104, 0);
        issue(0, 2'd2, 0, 32'h108, 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_init();
        chk("no_resp_across_reset", log32.size(), 0);

        log32.delete();
        issue(0, 2'd2, 0, 32'h100, 0);
        issue(0, 2'd0, 0, 32'h0, 0);
        issue(0, 2'd1, 0, 32'h2, 0);
        issue(0, 2'd2, 0, 32'h4, 0);
        issue(0, 2'd0, 1, 32'h5, 0);
        issue(1, 2'd2, 0, 32'h10, 32'hCAFE_F00D);
        issue(1, 2'd0, 0, 32'h20, 32'h0000_007F);
        issue(1, 2'd1, 0, 32'h22, 32'h0000_1234);
        issue(0, 2'd1, 0, 32'h1, 0);
        issue(1, 2'd3, 0, 32'h0, 0);
        issue(0, 2'd2, 1, 32'h20, 0);
        idle(RL + 3);
        check_log(0, "load_w100_cleared", 64'h0, 1'b0);
        check_log(10, "load_w20_after_stores", 64'h1234_007F, 1'b0);
`ifdef SDATAMEM_STATS_EN
        chk("stat_loads_literal", stat_loads, 6);
        chk("stat_stores_literal", stat_stores, 3);
        chk("stat_errs_literal", stat_errs, 2);
`endif

        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
